// File: rtl/key_cmd_sched.sv
// Debounced three-key command scheduler: INC/DEC auto-repeat, pending merge, one update per grant.
// Grant-to-valid latency 2 cycles; holds value/upd_cmd until upd_ready, events queue in pending meanwhile.
module key_cmd_sched #(
   parameter logic [19:0] DEB_CYCLES    = 20'd500000,
   parameter logic [25:0] HOLD_CYCLES   = 26'd25000000,
   parameter logic [23:0] REPEAT_CYCLES = 24'd5000000,
   parameter logic [19:0] MAX_VALUE     = 20'd1024,
   parameter logic [19:0] STEP          = 20'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  key,
   input  logic        upd_ready,
   output logic [19:0] value,
   output logic        upd_valid,
   output logic [1:0]  upd_cmd,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, APPLY, NOTIFY} state_t;

   logic [2:0]  sync1_q, sync2_q;
   logic [2:0]  deb_q, deb_d, rise;
   logic [1:0]  fall;
   logic [19:0] deb_cnt_q [3];
   logic [19:0] deb_cnt_d [3];
   logic [25:0] rep_cnt_q [2];
   logic [25:0] rep_cnt_d [2];
   logic [1:0]  rep_phase_q, rep_phase_d, rep_evt;
   logic [2:0]  evt, pend_q, pend_d, pend_clr;
   logic        ovf_hit, gnt_vld;
   logic [1:0]  gnt_idx;
   logic [20:0] sum_w;
   logic [19:0] value_nxt;

   state_t      state_q;
   logic [19:0] value_q;
   logic        upd_valid_q, busy_q, ovf_q;
   logic [1:0]  upd_cmd_q;

   // Level flips only once DEB_CYCLES consecutive samples disagree with it.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i]     = deb_q[i];
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] + 20'd1 >= DEB_CYCLES) deb_d[i] = sync2_q[i];
            else                                     deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
         end
      end
      rise = deb_d & ~deb_q;
      fall = deb_q[1:0] & ~deb_d[1:0];
   end

   // Phase 0 waits out the hold time, phase 1 ticks at the repeat period; a falling edge kills both.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rep_cnt_d[i]   = '0;
         rep_phase_d[i] = 1'b0;
         rep_evt[i]     = 1'b0;
         if (deb_q[i] && !fall[i]) begin
            rep_phase_d[i] = rep_phase_q[i];
            if (rep_cnt_q[i] + 26'd1 >= (rep_phase_q[i] ? {2'b00, REPEAT_CYCLES} : HOLD_CYCLES)) begin
               rep_evt[i]     = 1'b1;
               rep_phase_d[i] = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + 26'd1;
            end
         end
      end
      evt = rise | {1'b0, rep_evt};
   end

   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = 2'd0;
      pend_clr = '0;
      if (state_q == IDLE) begin
         if (pend_q[0])      begin gnt_vld = 1'b1; gnt_idx = 2'd0; pend_clr = 3'b001; end
         else if (pend_q[1]) begin gnt_vld = 1'b1; gnt_idx = 2'd1; pend_clr = 3'b010; end
         else if (pend_q[2]) begin gnt_vld = 1'b1; gnt_idx = 2'd2; pend_clr = 3'b100; end
      end
      // An event landing on the bit being granted re-arms it without counting as an overflow.
      pend_d  = (pend_q & ~pend_clr) | evt;
      ovf_hit = |(evt & pend_q & ~pend_clr);
   end

   always_comb begin
      sum_w     = {1'b0, value_q} + {1'b0, STEP};
      value_nxt = value_q;
      case (upd_cmd_q)
         2'd0:    value_nxt = (sum_w >= {1'b0, MAX_VALUE}) ? 20'd0 : sum_w[19:0];
         2'd1:    value_nxt = (value_q < STEP) ? MAX_VALUE - 20'd1 : value_q - STEP;
         2'd2:    value_nxt = 20'd0;
         default: value_nxt = value_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         deb_cnt_q   <= '{default: '0};
         rep_cnt_q   <= '{default: '0};
         rep_phase_q <= '0;
      end else begin
         sync1_q     <= key;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         value_q     <= '0;
         upd_valid_q <= 1'b0;
         upd_cmd_q   <= 2'd0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         pend_q <= pend_d;
         if (ovf_hit) ovf_q <= 1'b1;
         case (state_q)
            IDLE: if (gnt_vld) begin
               upd_cmd_q <= gnt_idx;
               busy_q    <= 1'b1;
               state_q   <= APPLY;
            end
            APPLY: begin
               value_q     <= value_nxt;
               upd_valid_q <= 1'b1;
               state_q     <= NOTIFY;
            end
            NOTIFY: if (upd_ready) begin
               upd_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign value     = value_q;
   assign upd_valid = upd_valid_q;
   assign upd_cmd   = upd_cmd_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule
